// File: rtl/ps2_cmd_pkg.sv
// Shared types and constants for the PS/2 command arbiter: FSM states,
// completion status codes and the mouse acknowledge bytes.
package ps2_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SENT,
    ST_WAIT_ACK,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_ERR     = 2'b01,
    STAT_TIMEOUT = 2'b10,
    STAT_NAK     = 2'b11
  } status_t;

  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_NAK = 8'hFE;
  localparam logic [7:0] PS2_ERR = 8'hFC;

endpackage

// File: rtl/ps2_cmd_timeout.sv
// Clearable up-counter that stops at LIMIT and raises hit while it sits there.
// hit is an equality test, so it rises exactly LIMIT cycles after the clear.
module ps2_cmd_timeout import ps2_cmd_pkg::*; #(
  parameter int LIMIT = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic hit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (clr)  count <= '0;
    else if (!hit) count <= count + W'(1);
  end

  assign hit = (count == W'(LIMIT));

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Shares one PS/2 transmitter/receiver pair between two command requesters,
// with NAK/timeout retry. Define ROUND_ROBIN_EN for round-robin arbitration.
module ps2_cmd_arbiter import ps2_cmd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] REQ,
  input  logic [7:0] CMD0,
  input  logic [7:0] CMD1,
  output logic [1:0] GNT,
  output logic [1:0] DONE,
  output logic [1:0] STATUS,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  input  logic       STREAM_READ_ENABLE,
  output logic       STREAM_BYTE_READY
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t        state, state_next;
  status_t       status_q, status_next;
  logic [RW-1:0] retries;
  logic          timer_clr, timer_hit;
  logic          grant, grant_idx, pick;
  logic          retry_path, retry_nak, retry_take;

  ps2_cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk (CLK),
    .rst (RESET),
    .clr (timer_clr),
    .hit (timer_hit)
  );

`ifdef ROUND_ROBIN_EN
  logic last_served;
  // On a tie the requester that was not served last wins.
  assign pick = (REQ == 2'b11) ? ~last_served : REQ[1];
`else
  assign pick = ~REQ[0];
`endif

  assign timer_clr = (state == ST_SEND) || ((state == ST_WAIT_SENT) && BYTE_SENT);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    status_next = status_q;
    grant       = 1'b0;
    grant_idx   = 1'b0;
    retry_path  = 1'b0;
    retry_nak   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|REQ) begin
          grant      = 1'b1;
          grant_idx  = pick;
          state_next = ST_SEND;
        end
      end
      ST_SEND: state_next = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (BYTE_SENT)      state_next = ST_WAIT_ACK;
        else if (timer_hit) retry_path = 1'b1;
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          if (BYTE_ERROR_CODE != 2'b00) begin
            state_next  = ST_RESP;
            status_next = STAT_ERR;
          end else if (BYTE_READ == PS2_ACK) begin
            state_next  = ST_RESP;
            status_next = STAT_OK;
          end else if (BYTE_READ == PS2_NAK) begin
            retry_path = 1'b1;
            retry_nak  = 1'b1;
          end else if (BYTE_READ == PS2_ERR) begin
            state_next  = ST_RESP;
            status_next = STAT_ERR;
          end else begin
            state_next  = ST_RESP;
            status_next = STAT_ERR;
          end
        end else if (timer_hit) begin
          retry_path = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (retry_path) begin
      if (retries < RW'(MAX_RETRY)) begin
        state_next = ST_SEND;
      end else begin
        state_next  = ST_RESP;
        status_next = retry_nak ? STAT_NAK : STAT_TIMEOUT;
      end
    end
  end

  assign retry_take = retry_path && (state_next == ST_SEND);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= ST_IDLE;
      status_q     <= STAT_OK;
      retries      <= '0;
      GNT          <= 2'b00;
      DONE         <= 2'b00;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
`ifdef ROUND_ROBIN_EN
      last_served  <= 1'b1;
`endif
    end else begin
      state     <= state_next;
      SEND_BYTE <= (state_next == ST_SEND);
      // GNT is still held on the edge into RESP, so it names the finisher.
      DONE      <= (state_next == ST_RESP) ? GNT : 2'b00;
      if (state_next == ST_RESP) begin
        status_q <= status_next;
        GNT      <= 2'b00;
      end
      if (grant) begin
        GNT          <= grant_idx ? 2'b10 : 2'b01;
        BYTE_TO_SEND <= grant_idx ? CMD1 : CMD0;
        retries      <= '0;
`ifdef ROUND_ROBIN_EN
        last_served  <= grant_idx;
`endif
      end else if (retry_take) begin
        retries <= retries + RW'(1);
      end
    end
  end

  assign STATUS            = status_q;
  assign READ_ENABLE       = (state == ST_IDLE) ? STREAM_READ_ENABLE : (state == ST_WAIT_ACK);
  assign STREAM_BYTE_READY = (state == ST_IDLE) && BYTE_READY;

endmodule

// File: tb/tb_ps2_cmd_arbiter.sv
// Directed bench for ps2_cmd_arbiter: acks, NAK retries, timeouts, arbitration
// order (fixed or round-robin, following ROUND_ROBIN_EN) and reset abandonment.
module tb_ps2_cmd_arbiter;

  localparam int T  = 100;
  localparam int MR = 2;

`ifdef ROUND_ROBIN_EN
  localparam int ARB_B = 1;
  localparam int ARB_C = 0;
`else
  localparam int ARB_B = 0;
  localparam int ARB_C = 1;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] REQ;
  logic [7:0] CMD0, CMD1;
  logic [1:0] GNT, DONE, STATUS;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic       STREAM_READ_ENABLE;
  logic       STREAM_BYTE_READY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int send_pulses = 0;
  int done_pulses = 0;
  bit gnt0_seen = 1'b0;

  ps2_cmd_arbiter #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .REQ                (REQ),
    .CMD0               (CMD0),
    .CMD1               (CMD1),
    .GNT                (GNT),
    .DONE               (DONE),
    .STATUS             (STATUS),
    .SEND_BYTE          (SEND_BYTE),
    .BYTE_TO_SEND       (BYTE_TO_SEND),
    .BYTE_SENT          (BYTE_SENT),
    .READ_ENABLE        (READ_ENABLE),
    .BYTE_READ          (BYTE_READ),
    .BYTE_ERROR_CODE    (BYTE_ERROR_CODE),
    .BYTE_READY         (BYTE_READY),
    .STREAM_READ_ENABLE (STREAM_READ_ENABLE),
    .STREAM_BYTE_READY  (STREAM_BYTE_READY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (SEND_BYTE)     send_pulses <= send_pulses + 1;
    if (DONE != 2'b00) done_pulses <= done_pulses + 1;
    if (GNT[0])        gnt0_seen   <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_send(input string tag, input int budget, output int waited);
    waited = 0;
    while (!SEND_BYTE && waited < budget) begin
      tick();
      waited++;
    end
    check({tag, " send seen"}, SEND_BYTE, 1);
  endtask

  // One full transaction for requester idx. replies holds one mouse byte per
  // attempt, attempt 0 in the low byte. With sent_ok=0 the transmitter never
  // finishes, so every attempt times out. Returns in the DONE cycle with the
  // served REQ bit dropped.
  task automatic transact(input string tag, input int idx, input logic [7:0] exp_byte,
                          input logic [23:0] replies, input int n_send, input bit sent_ok,
                          input logic [1:0] exp_status);
    int s0, last_send, n, w;
    logic [1:0] oh;
    oh = (idx == 1) ? 2'b10 : 2'b01;
    s0 = send_pulses;
    last_send = cyc;
    for (int a = 0; a < n_send; a++) begin
      wait_send(tag, 3 * T, w);
      if (a == 0) check({tag, " grant latency"}, w, 1);
      // A timed-out attempt spends 1 SEND cycle plus T+1 WAIT_SENT cycles.
      if (a > 0 && !sent_ok) check({tag, " resend gap"}, cyc - last_send, T + 2);
      last_send = cyc;
      check({tag, " byte"}, BYTE_TO_SEND, exp_byte);
      check({tag, " gnt"}, GNT, oh);
      tick();
      check({tag, " send width"}, SEND_BYTE, 0);
      if (sent_ok) begin
        BYTE_READ  = 8'hAA;
        BYTE_READY = 1'b1;
        check({tag, " stream gated"}, STREAM_BYTE_READY, 0);
        check({tag, " rd_en wait_sent"}, READ_ENABLE, 0);
        tick();
        BYTE_READY = 1'b0;
        BYTE_SENT  = 1'b1;
        tick();
        BYTE_SENT  = 1'b0;
        check({tag, " rd_en wait_ack"}, READ_ENABLE, 1);
        BYTE_READ  = replies[8*a +: 8];
        BYTE_READY = 1'b1;
        tick();
        BYTE_READY = 1'b0;
      end
    end
    n = 0;
    while (DONE == 2'b00 && n < 3 * T + 10) begin
      tick();
      n++;
    end
    check({tag, " done"}, DONE, oh);
    check({tag, " status"}, STATUS, exp_status);
    check({tag, " gnt in resp"}, GNT, 0);
    if (sent_ok) check({tag, " done latency"}, n, 0);
    else         check({tag, " timeout gap"}, cyc - last_send, T + 2);
    REQ[idx] = 1'b0;
    tick();
    check({tag, " send count"}, send_pulses - s0, n_send);
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    RESET = 1'b1;
    REQ = 2'b00;
    CMD0 = 8'h00;
    CMD1 = 8'h00;
    BYTE_SENT = 1'b0;
    BYTE_READ = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
    BYTE_READY = 1'b0;
    STREAM_READ_ENABLE = 1'b1;
    #1;
    check("rst gnt", GNT, 0);
    check("rst done", DONE, 0);
    check("rst status", STATUS, 0);
    check("rst send", SEND_BYTE, 0);
    check("rst byte", BYTE_TO_SEND, 0);
    check("rst rd_en follows 1", READ_ENABLE, 1);
    STREAM_READ_ENABLE = 1'b0;
    BYTE_READY = 1'b1;
    #1;
    check("rst rd_en follows 0", READ_ENABLE, 0);
    check("rst stream ready", STREAM_BYTE_READY, 1);
    BYTE_READY = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    gnt0_seen = 1'b0;

    // Requester 1 alone, mouse acks.
    STREAM_READ_ENABLE = 1'b1;
    CMD1 = 8'hF3;
    REQ = 2'b10;
    transact("req1 ack", 1, 8'hF3, 24'h0000FA, 1, 1'b1, 2'b00);
    check("req1 no gnt0", gnt0_seen, 0);
    check("idle after done rd_en", READ_ENABLE, 1);
    BYTE_READY = 1'b1;
    #1;
    check("idle after done stream", STREAM_BYTE_READY, 1);
    BYTE_READY = 1'b0;

    // Simultaneous requests, then requester 0 re-raises after its DONE.
    CMD0 = 8'hFF;
    CMD1 = 8'hE8;
    REQ = 2'b11;
    transact("arb first", 0, 8'hFF, 24'h0000FA, 1, 1'b1, 2'b00);
    REQ[0] = 1'b1;
    transact("arb second", ARB_B, (ARB_B == 1) ? 8'hE8 : 8'hFF, 24'h0000FA, 1, 1'b1, 2'b00);
    transact("arb third", ARB_C, (ARB_C == 1) ? 8'hE8 : 8'hFF, 24'h0000FA, 1, 1'b1, 2'b00);
    REQ = 2'b00;
    tick();

    CMD0 = 8'hF4;
    REQ = 2'b01;
    transact("nak then ack", 0, 8'hF4, 24'hFAFEFE, 3, 1'b1, 2'b00);
    REQ = 2'b01;
    transact("nak exhausted", 0, 8'hF4, 24'hFEFEFE, 3, 1'b1, 2'b11);
    REQ = 2'b01;
    transact("reply fc", 0, 8'hF4, 24'h0000FC, 1, 1'b1, 2'b01);
    BYTE_ERROR_CODE = 2'b01;
    REQ = 2'b01;
    transact("rx error", 0, 8'hF4, 24'h0000FA, 1, 1'b1, 2'b01);
    BYTE_ERROR_CODE = 2'b00;
    CMD1 = 8'hE6;
    REQ = 2'b10;
    transact("sent timeout", 1, 8'hE6, 24'h000000, 3, 1'b0, 2'b10);

    // Reset while waiting for the ack abandons the transaction.
    CMD0 = 8'hF4;
    REQ = 2'b01;
    wait_send("reset txn", 10, d0);
    tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
    check("reset txn wait_ack", READ_ENABLE, 1);
    STREAM_READ_ENABLE = 1'b0;
    d0 = done_pulses;
    #2;
    RESET = 1'b1;
    #1;
    check("mid rst gnt", GNT, 0);
    check("mid rst send", SEND_BYTE, 0);
    check("mid rst byte", BYTE_TO_SEND, 0);
    check("mid rst status", STATUS, 0);
    check("mid rst done", DONE, 0);
    check("mid rst rd_en", READ_ENABLE, 0);
    REQ = 2'b00;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    tick();
    tick();
    check("no done after rst", done_pulses - d0, 0);
    check("no gnt after rst", GNT, 0);
    STREAM_READ_ENABLE = 1'b1;
    BYTE_READ = 8'h08;
    BYTE_READY = 1'b1;
    #1;
    check("stream rd_en", READ_ENABLE, 1);
    check("stream byte ready", STREAM_BYTE_READY, 1);
    tick();
    BYTE_READY = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
